warmboot_sequencer: RTL

Sequences the hand-off from the USB bootloader to a user image through the iCE40 warmboot primitive. On a boot request it waits for the USB link to go quiet, then forces the USB pads into a detach condition (SE0) so the host sees a disconnect. After a settle interval it drives the warmboot select and BOOT inputs. It sits between `tinyfpga_bootloader` (request, image select, USB activity) and the SB_WARMBOOT / USB pad output-enable logic at board top level.

---
 rtl/warmboot_sequencer.sv | 68 ++++++
 1 files changed

// File: rtl/warmboot_sequencer.sv
// warmboot_sequencer: detaches USB, settles, then fires SB_WARMBOOT with the latched image index
module warmboot_sequencer #(
  parameter int IDLE_TIMEOUT  = 480000,
  parameter int DETACH_CYCLES = 48000,
  parameter int SETTLE_CYCLES = 480
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] image_sel_in,
  input  logic       boot_abort,
  input  logic       usb_busy,
  output logic       usb_detach,
  output logic [1:0] warmboot_s,
  output logic       warmboot_boot,
  output logic       seq_busy
);
  localparam int MAX_DS = DETACH_CYCLES > SETTLE_CYCLES ? DETACH_CYCLES : SETTLE_CYCLES;
  localparam int MAXC   = IDLE_TIMEOUT > MAX_DS ? IDLE_TIMEOUT : MAX_DS;
  localparam int CW     = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, DETACH, SETTLE, BOOT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic detach_q, detach_d, boot_q, boot_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        state_d = boot_req ? WAIT_IDLE : IDLE;
        sel_d   = boot_req ? image_sel_in : sel_q;
      end
      WAIT_IDLE: state_d = boot_abort ? IDLE :
                           (!usb_busy || cnt_q == CW'(IDLE_TIMEOUT)) ? DETACH : WAIT_IDLE;
      DETACH:    state_d = cnt_q == CW'(DETACH_CYCLES - 1) ? SETTLE : DETACH;
      SETTLE:    state_d = cnt_q == CW'(SETTLE_CYCLES - 1) ? BOOT : SETTLE;
      BOOT:      state_d = BOOT;
      default:   state_d = IDLE;
    endcase
    // counter restarts on every state entry and idles at zero where nothing is timed
    cnt_d    = (state_d != state_q || state_q == IDLE || state_q == BOOT) ? '0 : cnt_q + 1'b1;
    detach_d = state_d inside {DETACH, SETTLE, BOOT};
    boot_d   = state_d == BOOT;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      detach_q <= 1'b0;
      boot_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      detach_q <= detach_d;
      boot_q   <= boot_d;
      busy_q   <= busy_d;
    end
  end
  assign usb_detach    = detach_q;
  assign warmboot_s    = sel_q;
  assign warmboot_boot = boot_q;
  assign seq_busy      = busy_q;
endmodule
